// File: rtl/adc_scan_pkg.sv
// Shared types and defaults for the SAR scan sequencer.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        SMP  = 3'd2,
        CONV = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam int NCH_DEF   = 18;
    localparam int DACW_DEF  = 10;
    localparam int T_MUX_DEF = 4;
    localparam int T_SMP_DEF = 8;
    localparam int T_SET_DEF = 2;

    // Index width able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_ch_pick.sv
// Round-robin channel finder: lowest enabled channel at or above i_start,
// falling back to the lowest enabled channel overall (o_wrapped=1).
module adc_ch_pick #(
    parameter int NCH = 18,
    parameter int IW  = 5
) (
    input  logic [NCH-1:0] i_mask,
    input  logic [IW-1:0]  i_start,
    output logic           o_found,
    output logic [IW-1:0]  o_idx,
    output logic           o_wrapped
);

    logic          hit_hi;
    logic [IW-1:0] idx_hi;
    logic [IW-1:0] idx_lo;

    always_comb begin
        hit_hi = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                idx_lo = IW'(i);
                if (i >= int'(i_start)) begin
                    hit_hi = 1'b1;
                    idx_hi = IW'(i);
                end
            end
        end
        o_found   = |i_mask;
        o_wrapped = o_found && !hit_hi;
        o_idx     = hit_hi ? idx_hi : idx_lo;
    end

endmodule

// File: rtl/adc_scan_seq.sv
// Multi-channel SAR scan sequencer: mux select, sample/hold, binary search on DAC1,
// per-channel result capture and sticky over-threshold flags.
//
//  state | meaning
//  IDLE  | no channel selected, waiting for enable and a non-empty mask
//  SEL   | mux settling, sample/hold in reset (T_MUX cycles)
//  SMP   | tracking input (T_SMP cycles)
//  CONV  | holding, one SAR trial per T_SET cycles, MSB first
//  DONE  | result valid for one cycle, pick next channel
module adc_scan_seq
    import adc_scan_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DACW  = DACW_DEF,
    parameter int T_MUX = T_MUX_DEF,
    parameter int T_SMP = T_SMP_DEF,
    parameter int T_SET = T_SET_DEF
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   i_en,
    input  logic                   i_oneshot,
    input  logic [NCH-1:0]         i_ch_en,
    input  logic [NCH*DACW-1:0]    i_thr_hi,
    input  logic [NCH-1:0]         i_ovr_clr,
    input  logic                   i_comp,
    output logic [NCH-1:0]         o_cmp_sel,
    output logic                   o_ad_rst,
    output logic                   o_ad_hold,
    output logic                   o_dac1_en,
    output logic [DACW-1:0]        o_dac1,
    output logic                   o_res_vld,
    output logic [$clog2(NCH)-1:0] o_res_ch,
    output logic [DACW-1:0]        o_res_dat,
    output logic [NCH-1:0]         o_ovr,
    output logic                   o_done,
    output logic                   o_busy
);

    localparam int IW = idx_w(NCH);
    localparam int TW = idx_w(max3(T_MUX, T_SMP, T_SET));
    localparam int BW = idx_w(DACW);

    state_e          state_q, state_d;
    logic [IW-1:0]   ch_q, ch_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   start_q, start_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DACW-1:0] code_q, code_d;
    logic [IW-1:0]   res_ch_q, res_ch_d;
    logic [DACW-1:0] res_dat_q, res_dat_d;
    logic [NCH-1:0]  ovr_q, ovr_d;
    logic            hold_q, hold_d;

    logic [IW-1:0]   ch_nxt;
    logic [IW-1:0]   pick_start;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            pick_wrapped;
    logic            tmr_tc;
    logic [DACW-1:0] trial;
    logic [DACW-1:0] code_tri;
    logic            scan_end;
    logic            last_ch;
    logic [DACW-1:0] thr_cur;

    assign ch_nxt     = (ch_q == IW'(NCH - 1)) ? '0 : ch_q + 1'b1;
    assign pick_start = (state_q == IDLE) ? ptr_q : ch_nxt;
    assign tmr_tc     = (tmr_q == '0);
    assign trial      = code_q | (DACW'(1) << bit_q);
    assign code_tri   = i_comp ? trial : (trial & ~(DACW'(1) << bit_q));
    assign thr_cur    = i_thr_hi[int'(ch_q)*DACW +: DACW];

    // The scan is complete once the search window from ch+1 to the next hit covers the start channel.
    assign scan_end = pick_wrapped ? (start_q >= pick_start || start_q <= pick_idx)
                                   : (start_q >= pick_start && start_q <= pick_idx);
    assign last_ch  = i_oneshot && scan_end;

    adc_ch_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .i_mask    (i_ch_en),
        .i_start   (pick_start),
        .o_found   (pick_found),
        .o_idx     (pick_idx),
        .o_wrapped (pick_wrapped)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_found && !hold_q)      state_d = SEL;
            SEL:     if (tmr_tc)                     state_d = SMP;
            SMP:     if (tmr_tc)                     state_d = CONV;
            CONV:    if (tmr_tc && bit_q == '0)      state_d = DONE;
            DONE:    state_d = (!pick_found || last_ch) ? IDLE : SEL;
            default: state_d = IDLE;
        endcase
        if (!i_en) state_d = IDLE;
    end

    always_comb begin
        ch_d      = ch_q;
        ptr_d     = ptr_q;
        start_d   = start_q;
        tmr_d     = tmr_tc ? tmr_q : tmr_q - 1'b1;
        bit_d     = bit_q;
        code_d    = code_q;
        res_ch_d  = res_ch_q;
        res_dat_d = res_dat_q;
        ovr_d     = ovr_q & ~i_ovr_clr;
        hold_d    = hold_q & i_en & i_oneshot;
        unique case (state_q)
            IDLE: begin
                if (state_d == SEL) begin
                    ch_d    = pick_idx;
                    start_d = pick_idx;
                    code_d  = '0;
                    tmr_d   = TW'(T_MUX - 1);
                end
            end
            SEL: begin
                if (tmr_tc) tmr_d = TW'(T_SMP - 1);
            end
            SMP: begin
                if (tmr_tc) begin
                    tmr_d = TW'(T_SET - 1);
                    bit_d = BW'(DACW - 1);
                end
            end
            CONV: begin
                if (tmr_tc) begin
                    code_d = code_tri;
                    if (bit_q == '0) begin
                        if (i_en) begin
                            res_ch_d  = ch_q;
                            res_dat_d = code_tri;
                        end
                    end else begin
                        bit_d = bit_q - 1'b1;
                        tmr_d = TW'(T_SET - 1);
                    end
                end
            end
            DONE: begin
                if (res_dat_q > thr_cur) ovr_d[ch_q] = 1'b1;
                ptr_d = ch_nxt;
                if (pick_found && last_ch) begin
                    ptr_d  = '0;
                    hold_d = i_en;
                end else if (pick_found) begin
                    ch_d   = pick_idx;
                    code_d = '0;
                    tmr_d  = TW'(T_MUX - 1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ch_q      <= '0;
            ptr_q     <= '0;
            start_q   <= '0;
            tmr_q     <= '0;
            bit_q     <= '0;
            code_q    <= '0;
            res_ch_q  <= '0;
            res_dat_q <= '0;
            ovr_q     <= '0;
            hold_q    <= 1'b0;
        end else begin
            ch_q      <= ch_d;
            ptr_q     <= ptr_d;
            start_q   <= start_d;
            tmr_q     <= tmr_d;
            bit_q     <= bit_d;
            code_q    <= code_d;
            res_ch_q  <= res_ch_d;
            res_dat_q <= res_dat_d;
            ovr_q     <= ovr_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        o_cmp_sel = '0;
        if (state_q != IDLE) o_cmp_sel[ch_q] = 1'b1;
        o_ad_rst  = (state_q == SEL);
        o_ad_hold = (state_q == CONV);
        o_dac1_en = (state_q != IDLE);
        o_dac1    = (state_q == CONV) ? trial : '0;
        o_res_vld = (state_q == DONE);
        o_done    = (state_q == DONE) && pick_found && last_ch;
        o_busy    = (state_q != IDLE);
    end

    assign o_res_ch  = res_ch_q;
    assign o_res_dat = res_dat_q;
    assign o_ovr     = ovr_q;

endmodule
